// File: rtl/led_sequencer_pkg.sv
// Shared encodings and constants for the LED pattern sequencer.
package led_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam int PWM_BITS   = 3;
  localparam int RATE_BITS  = 3;
  localparam int BRIGHT_MAX = 8;

  // Brightness 8..15 all mean "always on", so clamp to 8.
  function automatic logic [3:0] sat_bright(input logic [3:0] b);
    return (b > 4'(BRIGHT_MAX)) ? 4'(BRIGHT_MAX) : b;
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Step-period prescaler: tick marks the last cycle of each 2^(PRESCALE_BASE+rate) period.
module led_prescaler
  import led_sequencer_pkg::*;
#(
  parameter int PRESCALE_BASE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [RATE_BITS-1:0] rate,
  output logic                 tick
);

  localparam int CNT_W = PRESCALE_BASE + 7;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] terminal;

  // Terminal count; at rate 7 the shift overflows to zero so the result is all-ones.
  always_comb begin
    terminal = (CNT_W'(1) << (PRESCALE_BASE + int'(rate))) - CNT_W'(1);
    tick     = (cnt_q == terminal);
    cnt_d    = cnt_q + CNT_W'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: command FSM, pattern generator and PWM output stage.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// cmd_ready drops for the single APPLY cycle and a held cmd_valid simply waits.
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int PRESCALE_BASE = 16,
  parameter int NUM_LEDS      = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_mode,
  input  logic [RATE_BITS-1:0] cmd_rate,
  input  logic [3:0]           cmd_bright,
  output logic [NUM_LEDS-1:0]  led,
  output logic                 step
);

  state_e                state_q,   state_d;
  mode_e                 mode_q,    mode_d;
  logic [RATE_BITS-1:0]  rate_q,    rate_d;
  logic [3:0]            bright_q,  bright_d;
  logic [NUM_LEDS-1:0]   pattern_q, pattern_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [NUM_LEDS-1:0]   led_q,     led_d;
  logic                  tick;

  // Prescaler only counts while running, so every new pattern starts a full period.
  led_prescaler #(
    .PRESCALE_BASE (PRESCALE_BASE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_q != ST_RUN),
    .rate  (rate_q),
    .tick  (tick)
  );

  // Next-state, config capture, pattern update and PWM gating.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    rate_d    = rate_q;
    bright_d  = bright_q;
    pattern_d = pattern_q;
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    cmd_ready = (state_q != ST_APPLY);
    step      = tick && (state_q == ST_RUN);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          mode_d   = mode_e'(cmd_mode);
          rate_d   = cmd_rate;
          bright_d = sat_bright(cmd_bright);
          state_d  = ST_APPLY;
        end
      end
      ST_APPLY: begin
        pwm_cnt_d = '0;
        state_d   = ST_RUN;
        case (mode_q)
          MODE_BLINK: pattern_d = '1;
          MODE_CHASE: pattern_d = NUM_LEDS'(1);
          default:    pattern_d = '0;
        endcase
      end
      ST_RUN: begin
        if (tick) begin
          case (mode_q)
            MODE_BLINK: pattern_d = ~pattern_q;
            MODE_CHASE: pattern_d = {pattern_q[NUM_LEDS-2:0], pattern_q[NUM_LEDS-1]};
            MODE_COUNT: pattern_d = pattern_q + NUM_LEDS'(1);
            default:    pattern_d = '0;
          endcase
        end
        if (cmd_valid) begin
          mode_d   = mode_e'(cmd_mode);
          rate_d   = cmd_rate;
          bright_d = sat_bright(cmd_bright);
          state_d  = ST_APPLY;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    led_d = pattern_q & {NUM_LEDS{({1'b0, pwm_cnt_q} < bright_q)}};
    if (state_q == ST_IDLE) begin
      led_d = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_OFF;
      rate_q    <= '0;
      bright_q  <= '0;
      pattern_q <= '0;
      pwm_cnt_q <= '0;
      led_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      rate_q    <= rate_d;
      bright_q  <= bright_d;
      pattern_q <= pattern_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with PRESCALE_BASE=2, five LEDs.
module tb_led_sequencer;
  import led_sequencer_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [2:0] cmd_rate;
  logic [3:0] cmd_bright;
  logic [4:0] led;
  logic       step;

  int total = 0;
  int bad   = 0;

  led_sequencer #(
    .PRESCALE_BASE (2),
    .NUM_LEDS      (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_rate   (cmd_rate),
    .cmd_bright (cmd_bright),
    .led        (led),
    .step       (step)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, landing 1 unit after the rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one command; returns 1 unit after edge N+2 (N = accept edge).
  task automatic send_cmd(input logic [1:0] m, input logic [2:0] r, input logic [3:0] b);
    cmd_valid  = 1'b1;
    cmd_mode   = m;
    cmd_rate   = r;
    cmd_bright = b;
    cyc(1);
    chk("apply_ready_low", 32'(cmd_ready), 32'd0);
    chk("apply_no_step", 32'(step), 32'd0);
    cmd_valid = 1'b0;
    cyc(2);
  endtask

  initial begin
    int steps_seen;
    int led_nonzero;
    int ones_cnt;
    int other_cnt;

    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_mode   = 2'd0;
    cmd_rate   = 3'd0;
    cmd_bright = 4'd0;

    // Reset state.
    #2;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    cyc(3);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);

    // Idle for 1000 cycles: nothing moves.
    steps_seen  = 0;
    led_nonzero = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc(1);
      if (step) steps_seen++;
      if (led != 5'd0) led_nonzero++;
    end
    chk("idle_steps", 32'(steps_seen), 32'd0);
    chk("idle_led", 32'(led_nonzero), 32'd0);
    chk("idle_ready", 32'(cmd_ready), 32'd1);

    // CHASE, rate 0, bright 8.
    send_cmd(2'd2, 3'd0, 4'd8);
    chk("chase_init", 32'(led), 32'b00001);
    cyc(2);
    chk("chase_step_pulse", 32'(step), 32'd1);
    cyc(1);
    chk("chase_step_one_cycle", 32'(step), 32'd0);
    cyc(1);
    chk("chase_1", 32'(led), 32'b00010);
    cyc(4);
    chk("chase_2", 32'(led), 32'b00100);
    cyc(4);
    chk("chase_3", 32'(led), 32'b01000);
    cyc(4);
    chk("chase_4", 32'(led), 32'b10000);
    cyc(4);
    chk("chase_wrap", 32'(led), 32'b00001);

    // Asynchronous reset between edges in the middle of CHASE.
    cyc(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_led", 32'(led), 32'd0);
    chk("async_rst_ready", 32'(cmd_ready), 32'd1);
    chk("async_rst_step", 32'(step), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);
    chk("post_rst_idle", 32'(dut.state_q), 32'(ST_IDLE));
    chk("post_rst_led", 32'(led), 32'd0);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    // COUNT, rate 1, bright 8: increments every 8 cycles, wraps 31 -> 0.
    send_cmd(2'd3, 3'd1, 4'd8);
    chk("count_init", 32'(led), 32'd0);
    for (int i = 1; i <= 32; i++) begin
      cyc(8);
      chk($sformatf("count_%0d", i), 32'(led), 32'(i % 32));
    end

    // BLINK, rate 0, bright 3: 3 lit cycles per 8-cycle window while pattern is ones.
    send_cmd(2'd1, 3'd0, 4'd3);
    chk("blink_b3_first", 32'(led), 32'h1f);
    ones_cnt  = 0;
    other_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (led == 5'h1f) ones_cnt++;
      else if (led != 5'd0) other_cnt++;
      cyc(1);
    end
    chk("blink_b3_ones", 32'(ones_cnt), 32'd6);
    chk("blink_b3_partial", 32'(other_cnt), 32'd0);

    // BLINK, bright 0: dark throughout.
    send_cmd(2'd1, 3'd0, 4'd0);
    led_nonzero = 0;
    for (int i = 0; i < 16; i++) begin
      if (led != 5'd0) led_nonzero++;
      cyc(1);
    end
    chk("blink_b0_dark", 32'(led_nonzero), 32'd0);

    // BLINK, bright 15 saturates to always on: 4 of 8 cycles lit.
    send_cmd(2'd1, 3'd0, 4'd15);
    ones_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (led == 5'h1f) ones_cnt++;
      cyc(1);
    end
    chk("blink_b15_ones", 32'(ones_cnt), 32'd4);

    // OFF: stays dark.
    send_cmd(2'd0, 3'd0, 4'd8);
    led_nonzero = 0;
    for (int i = 0; i < 8; i++) begin
      if (led != 5'd0) led_nonzero++;
      cyc(1);
    end
    chk("off_dark", 32'(led_nonzero), 32'd0);

    // cmd_valid held across accept: second command taken one cycle after APPLY.
    cmd_valid  = 1'b1;
    cmd_mode   = 2'd2;
    cmd_rate   = 3'd0;
    cmd_bright = 4'd8;
    cyc(1);
    chk("held_apply_ready", 32'(cmd_ready), 32'd0);
    cmd_mode = 2'd3;
    cyc(1);
    chk("held_run_ready", 32'(cmd_ready), 32'd1);
    cyc(1);
    chk("held_second_apply", 32'(cmd_ready), 32'd0);
    chk("held_apply_step", 32'(step), 32'd0);
    chk("held_chase_init", 32'(led), 32'b00001);
    cmd_valid = 1'b0;
    cyc(2);
    chk("held_count_init", 32'(led), 32'd0);
    cyc(4);
    chk("held_count_first", 32'(led), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
